// File: rtl/alu_pkg.sv
// Shared opcode, type and FSM state definitions for the ALU command sequencer.
package alu_pkg;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_ADD = 4'd0;
  localparam opcode_t OP_SUB = 4'd1;
  localparam opcode_t OP_AND = 4'd2;
  localparam opcode_t OP_OR  = 4'd3;
  localparam opcode_t OP_SLL = 4'd4;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } seq_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO with explicit entry count; pointers wrap naturally (Depth is a power of two).
module alu_cmd_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PtrW:0]    count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q, count_d;
  logic             push_en, pop_en;

  assign full_o  = (count_q == (PtrW + 1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Full blocks push even if a pop happens in the same cycle.
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command-issue stage for the combinational ALU: FIFO, registered operands, tagged response.
// Optional carry/borrow return enabled by defining ALU_SEQ_CARRY_EN.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned Width  = 128,
  parameter int unsigned ShamtW = 5,
  parameter int unsigned Depth  = 4,
  parameter int unsigned TagW   = 4,
  localparam int unsigned OccW  = $clog2(Depth) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [3:0]        cmd_opcode_i,
  input  logic [Width-1:0]  cmd_a_i,
  input  logic [Width-1:0]  cmd_b_i,
  input  logic [ShamtW-1:0] cmd_shamt_i,
  input  logic [TagW-1:0]   cmd_tag_i,
  output logic [3:0]        alu_opcode_o,
  output logic [Width-1:0]  alu_input1_o,
  output logic [Width-1:0]  alu_input2_o,
  output logic [ShamtW-1:0] alu_shift_o,
  input  logic [Width-1:0]  alu_result_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [Width-1:0]  rsp_result_o,
  output logic              rsp_carry_o,
  output logic [TagW-1:0]   rsp_tag_o,
  output logic [OccW-1:0]   occupancy_o
);

  localparam int unsigned EntryW = 4 + 2 * Width + ShamtW + TagW;

  seq_state_e state_q, state_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [EntryW-1:0] fifo_wdata, fifo_rdata;

  opcode_t           head_op;
  logic [Width-1:0]  head_a, head_b;
  logic [ShamtW-1:0] head_shamt;
  logic [TagW-1:0]   head_tag;

  opcode_t           alu_opcode_q;
  logic [Width-1:0]  alu_a_q, alu_b_q;
  logic [ShamtW-1:0] alu_shift_q;
  logic [TagW-1:0]   tag_q;
  logic [Width-1:0]  rsp_result_q;
  logic [TagW-1:0]   rsp_tag_q;

  assign cmd_ready_o = !fifo_full;
  assign fifo_push   = cmd_valid_i && cmd_ready_o;
  assign fifo_wdata  = {cmd_opcode_i, cmd_a_i, cmd_b_i, cmd_shamt_i, cmd_tag_i};
  assign {head_op, head_a, head_b, head_shamt, head_tag} = fifo_rdata;

  alu_cmd_fifo #(
    .Width (EntryW),
    .Depth (Depth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (occupancy_o)
  );

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = StExec;
        end
      end
      StExec: state_d = StResp;
      StResp: begin
        if (rsp_ready_i) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = StExec;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_shift_q  <= '0;
      tag_q        <= '0;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
    end else begin
      state_q <= state_d;
      if (fifo_pop) begin
        alu_opcode_q <= head_op;
        alu_a_q      <= head_a;
        alu_b_q      <= head_b;
        alu_shift_q  <= head_shamt;
        tag_q        <= head_tag;
      end
      // ALU inputs have been stable for the whole EXEC cycle, so the result has settled.
      if (state_q == StExec) begin
        rsp_result_q <= alu_result_i;
        rsp_tag_q    <= tag_q;
      end
    end
  end

`ifdef ALU_SEQ_CARRY_EN
  logic [Width:0] sum_ext;
  logic           carry_d, rsp_carry_q;

  always_comb begin
    sum_ext = {1'b0, alu_a_q} + {1'b0, alu_b_q};
    carry_d = 1'b0;
    if (alu_opcode_q == OP_ADD) begin
      carry_d = sum_ext[Width];
    end else if (alu_opcode_q == OP_SUB) begin
      carry_d = (alu_a_q < alu_b_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_carry_q <= 1'b0;
    end else if (state_q == StExec) begin
      rsp_carry_q <= carry_d;
    end
  end

  assign rsp_carry_o = rsp_carry_q;
`else
  assign rsp_carry_o = 1'b0;
`endif

  assign alu_opcode_o = alu_opcode_q;
  assign alu_input1_o = alu_a_q;
  assign alu_input2_o = alu_b_q;
  assign alu_shift_o  = alu_shift_q;
  assign rsp_valid_o  = (state_q == StResp);
  assign rsp_result_o = rsp_result_q;
  assign rsp_tag_o    = rsp_tag_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer with a behavioural ALU attached.
module tb_alu_cmd_sequencer;

  localparam int unsigned Width  = 128;
  localparam int unsigned ShamtW = 5;
  localparam int unsigned Depth  = 4;
  localparam int unsigned TagW   = 4;
  localparam int unsigned OccW   = $clog2(Depth) + 1;

`ifdef ALU_SEQ_CARRY_EN
  localparam bit CarryEn = 1'b1;
`else
  localparam bit CarryEn = 1'b0;
`endif

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpSll = 4'd4;

  logic              clk, rst_n;
  logic              cmd_valid, cmd_ready;
  logic [3:0]        cmd_opcode;
  logic [Width-1:0]  cmd_a, cmd_b;
  logic [ShamtW-1:0] cmd_shamt;
  logic [TagW-1:0]   cmd_tag;
  logic [3:0]        alu_opcode;
  logic [Width-1:0]  alu_input1, alu_input2, alu_result;
  logic [ShamtW-1:0] alu_shift;
  logic              rsp_valid, rsp_ready, rsp_carry;
  logic [Width-1:0]  rsp_result;
  logic [TagW-1:0]   rsp_tag;
  logic [OccW-1:0]   occupancy;

  typedef struct {
    logic [TagW-1:0]  tag;
    logic [Width-1:0] res;
    logic             carry;
    int               cyc;
  } rsp_t;

  rsp_t obs_q[$];
  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  alu_cmd_sequencer dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_opcode_i (cmd_opcode),
    .cmd_a_i      (cmd_a),
    .cmd_b_i      (cmd_b),
    .cmd_shamt_i  (cmd_shamt),
    .cmd_tag_i    (cmd_tag),
    .alu_opcode_o (alu_opcode),
    .alu_input1_o (alu_input1),
    .alu_input2_o (alu_input2),
    .alu_shift_o  (alu_shift),
    .alu_result_i (alu_result),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_result_o (rsp_result),
    .rsp_carry_o  (rsp_carry),
    .rsp_tag_o    (rsp_tag),
    .occupancy_o  (occupancy)
  );

  function automatic logic [Width-1:0] alu_fn(input logic [3:0] op, input logic [Width-1:0] a,
                                              input logic [Width-1:0] b,
                                              input logic [ShamtW-1:0] sh);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a << sh;
      default: return '0;
    endcase
  endfunction

  function automatic logic carry_fn(input logic [3:0] op, input logic [Width-1:0] a,
                                    input logic [Width-1:0] b);
    logic [Width:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (op == OpAdd) return CarryEn & s[Width];
    if (op == OpSub) return CarryEn & (a < b);
    return 1'b0;
  endfunction

  assign alu_result = alu_fn(alu_opcode, alu_input1, alu_input2, alu_shift);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Handshake completes at the following rising edge; inputs only change just after edges.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      rsp_t r;
      r.tag   = rsp_tag;
      r.res   = rsp_result;
      r.carry = rsp_carry;
      r.cyc   = cyc;
      obs_q.push_back(r);
    end
  end

  task automatic check(input string name, input logic [Width:0] got, input logic [Width:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic push(input logic [3:0] op, input logic [Width-1:0] a, input logic [Width-1:0] b,
                      input logic [ShamtW-1:0] sh, input logic [TagW-1:0] tag);
    bit   accepted = 1'b0;
    rsp_t e;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    cmd_shamt  = sh;
    cmd_tag    = tag;
    cmd_valid  = 1'b1;
    for (int i = 0; i < 64 && !accepted; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk);
        accepted = 1'b1;
      end
    end
    #1 cmd_valid = 1'b0;
    if (accepted) begin
      e.tag   = tag;
      e.res   = alu_fn(op, a, b, sh);
      e.carry = carry_fn(op, a, b);
      e.cyc   = 0;
      exp_q.push_back(e);
    end else begin
      check("push_timeout", 0, 1);
    end
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 200 && obs_q.size() < n; i++) @(posedge clk);
    #1;
    check("rsp_count", obs_q.size(), n);
  endtask

  task automatic cmp_rsps(input int n);
    rsp_t o, e;
    for (int i = 0; i < n && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check("rsp_tag", o.tag, e.tag);
      check("rsp_result", o.res, e.res);
      check("rsp_carry", o.carry, e.carry);
    end
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_cmd_ready"}, cmd_ready, 1);
    check({pfx, "_occupancy"}, occupancy, 0);
    check({pfx, "_rsp_valid"}, rsp_valid, 0);
    check({pfx, "_rsp_result"}, rsp_result, 0);
    check({pfx, "_rsp_carry"}, rsp_carry, 0);
    check({pfx, "_rsp_tag"}, rsp_tag, 0);
    check({pfx, "_alu_opcode"}, alu_opcode, 0);
    check({pfx, "_alu_input1"}, alu_input1, 0);
    check({pfx, "_alu_input2"}, alu_input2, 0);
    check({pfx, "_alu_shift"}, alu_shift, 0);
  endtask

  initial begin
    logic [Width-1:0] ones, ones_m1, bit31;
    rsp_t             o;
    ones    = '1;
    ones_m1 = ones - 1;
    bit31   = '0;
    bit31[31] = 1'b1;

    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_opcode = '0; cmd_a = '0; cmd_b = '0; cmd_shamt = '0; cmd_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    rst_n = 1'b1;

    // Single ADD with carry-out, latency and hold under backpressure.
    push(OpAdd, ones, 128'd1, 5'd0, 4'd3);
    @(negedge clk);
    check("lat_t1_valid", rsp_valid, 0);
    @(negedge clk);
    check("lat_t2_valid", rsp_valid, 0);
    check("exec_alu_op", alu_opcode, OpAdd);
    check("exec_alu_a", alu_input1, ones);
    check("exec_alu_b", alu_input2, 128'd1);
    @(negedge clk);
    check("lat_t3_valid", rsp_valid, 1);
    check("add_result", rsp_result, 0);
    check("add_carry", rsp_carry, CarryEn);
    check("add_tag", rsp_tag, 3);
    repeat (2) @(negedge clk);
    check("hold_valid", rsp_valid, 1);
    check("hold_result", rsp_result, 0);
    check("hold_alu_a", alu_input1, ones);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check("add_drained_valid", rsp_valid, 0);
    obs_q.delete();
    exp_q.delete();

    // SUB with borrow, then SLL.
    rsp_ready = 1'b1;
    push(OpSub, 128'd5, 128'd7, 5'd0, 4'd1);
    push(OpSll, 128'd1, 128'd0, 5'd31, 4'd2);
    wait_rsp(2);
    if (obs_q.size() >= 2) begin
      o = obs_q.pop_front();
      check("sub_result", o.res, ones_m1);
      check("sub_carry", o.carry, CarryEn);
      check("sub_tag", o.tag, 1);
      o = obs_q.pop_front();
      check("sll_result", o.res, bit31);
      check("sll_carry", o.carry, 0);
      check("sll_tag", o.tag, 2);
    end
    exp_q.delete();

    // Unsupported opcode still yields a zero response.
    push(4'd9, 128'hFF, 128'hFF, 5'd0, 4'd7);
    wait_rsp(1);
    if (obs_q.size() >= 1) begin
      o = obs_q.pop_front();
      check("ill_result", o.res, 0);
      check("ill_carry", o.carry, 0);
      check("ill_tag", o.tag, 7);
    end
    exp_q.delete();
    obs_q.delete();

    // Fill under backpressure: one captured, four buffered, sixth stalls.
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(4'(i % 5), Width'(i + 1) * Width'(64'h0123_4567_89AB_CDEF), ones - Width'(i * 3),
           ShamtW'(i * 7), TagW'(i));
    end
    fork
      push(OpSub, 128'd10, 128'd20, 5'd0, 4'd5);
      begin
        repeat (3) @(negedge clk);
        check("fill_occupancy", occupancy, 4);
        check("fill_cmd_ready", cmd_ready, 0);
        check("fill_rsp_valid", rsp_valid, 1);
        check("fill_rsp_tag", rsp_tag, 0);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
    join
    wait_rsp(6);
    cmp_rsps(6);
    obs_q.delete();
    exp_q.delete();

    // Streaming with the consumer always ready: one response every two cycles.
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(4'(i % 5), Width'(i * 1000 + 17), Width'(i * 333 + 1), ShamtW'(i + 1), TagW'(i + 8));
    end
    wait_rsp(8);
    for (int i = 1; i < 8 && i < obs_q.size(); i++) begin
      check("stream_interval", obs_q[i].cyc - obs_q[i-1].cyc, 2);
    end
    cmp_rsps(8);
    obs_q.delete();
    exp_q.delete();

    // Reset during EXEC with three commands buffered.
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    push(OpAdd, 128'd1, 128'd2, 5'd0, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 1; i < 5; i++) push(OpAdd, Width'(i), Width'(i), 5'd0, TagW'(i));
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check("pre_rst_occupancy", occupancy, 3);
    check("pre_rst_alu_a", alu_input1, 128'd1);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    obs_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("post_rst_no_rsp", obs_q.size(), 0);
    check("post_rst_occupancy", occupancy, 0);
    check("post_rst_valid", rsp_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
